// File: rtl/ctrl_pipe_unit.sv
// Decode-to-EX control pipeline register with a multiply/divide occupancy sequencer.
// The EX bundle is loaded from a combinational decode and held while a multi-cycle M op owns EX.
module ctrl_pipe_unit #(
  parameter int ALUOP_W       = 5,
  parameter bit MULDIV_EN     = 1'b1,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_0,
  input  logic               hazard_stall,
  input  logic               flush,
  output logic               ex_regwrite,
  output logic               ex_alusrc,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_beq,
  output logic               ex_bne,
  output logic               ex_jal,
  output logic               ex_jalr,
  output logic               ex_word_or_byte,
  output logic [1:0]         ex_memtoreg,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_valid,
  output logic               ex_illegal,
  output logic               md_start,
  output logic               md_busy
);

  typedef struct packed {
    logic               regwrite;
    logic               alusrc;
    logic               memread;
    logic               memwrite;
    logic               beq;
    logic               bne;
    logic               jal;
    logic               jalr;
    logic               word_or_byte;
    logic [1:0]         memtoreg;
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
  } ctrl_t;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [4:0] CNT_INIT = 5'(MULDIV_CYCLES - 1);

  ctrl_t      dec;
  logic       dec_md;
  ctrl_t      ex_q;
  state_t     state;
  logic [4:0] cnt;

  // NOTE: every field gets a default before the case so no path leaves a value unassigned (no latch).
  always_comb begin
    dec    = '0;
    dec_md = 1'b0;
    unique case (opcode)
      7'h03: begin
        if (funct3 == 3'b000 || funct3 == 3'b010) begin
          dec.memread      = 1'b1;
          dec.memtoreg     = 2'b01;
          dec.alusrc       = 1'b1;
          dec.regwrite     = 1'b1;
          dec.aluop        = ALUOP_W'(4'b0110);
          dec.word_or_byte = (funct3 == 3'b000);
        end else dec.illegal = 1'b1;
      end
      7'h0D: begin
        if (funct3 == 3'b110 || funct3 == 3'b111) begin
          dec.aluop    = (funct3 == 3'b110) ? ALUOP_W'(4'b0101) : ALUOP_W'(4'b0011);
          dec.alusrc   = 1'b1;
          dec.regwrite = 1'b1;
        end else dec.illegal = 1'b1;
      end
      7'h1B: begin
        if (funct3 == 3'b000) begin
          dec.aluop    = ALUOP_W'(4'b0110);
          dec.alusrc   = 1'b1;
          dec.regwrite = 1'b1;
        end else dec.illegal = 1'b1;
      end
      7'h23: begin
        if (funct3 == 3'b000 || funct3 == 3'b010) begin
          dec.memwrite     = 1'b1;
          dec.alusrc       = 1'b1;
          dec.aluop        = ALUOP_W'(4'b0110);
          dec.word_or_byte = (funct3 == 3'b000);
        end else dec.illegal = 1'b1;
      end
      7'h33: begin
        if (!funct7_0) begin
          dec.aluop    = ALUOP_W'({1'b0, funct3});
          dec.regwrite = 1'b1;
        end else if (MULDIV_EN) begin
          dec.aluop    = ALUOP_W'({2'b10, funct3});
          dec.regwrite = 1'b1;
          dec_md       = 1'b1;
        end else dec.illegal = 1'b1;
      end
      7'h38: begin
        dec.aluop    = ALUOP_W'(4'b1000);
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      7'h63: begin
        if (funct3 == 3'b000) begin
          dec.bne   = 1'b1;
          dec.aluop = ALUOP_W'(4'b0111);
        end else if (funct3 == 3'b001) begin
          dec.beq   = 1'b1;
          dec.aluop = ALUOP_W'(4'b0001);
        end else dec.illegal = 1'b1;
      end
      7'h67: begin
        if (funct3 == 3'b000) begin
          dec.jalr     = 1'b1;
          dec.aluop    = ALUOP_W'(4'b0110);
          dec.alusrc   = 1'b1;
          dec.regwrite = 1'b1;
        end else dec.illegal = 1'b1;
      end
      7'h6F: begin
        dec.jal      = 1'b1;
        dec.aluop    = ALUOP_W'(4'b0110);
        dec.memtoreg = 2'b10;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= '0;
      ex_valid <= 1'b0;
      md_start <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
    end else begin
      md_start <= 1'b0;
      if (flush) begin
        ex_q     <= '0;
        ex_valid <= 1'b0;
        state    <= IDLE;
        cnt      <= '0;
      end else if (state == BUSY) begin
        // EX holds; the first IDLE edge afterwards takes the next decode.
        if (cnt == 5'd1) state <= IDLE;
        cnt <= cnt - 5'd1;
      end else if (hazard_stall) begin
        ex_q     <= '0;
        ex_valid <= 1'b0;
      end else begin
        ex_q     <= dec;
        ex_valid <= 1'b1;
        if (dec_md) begin
          md_start <= 1'b1;
          cnt      <= CNT_INIT;
          state    <= BUSY;
        end
      end
    end
  end

  assign md_busy         = (state == BUSY);
  assign ex_regwrite     = ex_q.regwrite;
  assign ex_alusrc       = ex_q.alusrc;
  assign ex_memread      = ex_q.memread;
  assign ex_memwrite     = ex_q.memwrite;
  assign ex_beq          = ex_q.beq;
  assign ex_bne          = ex_q.bne;
  assign ex_jal          = ex_q.jal;
  assign ex_jalr         = ex_q.jalr;
  assign ex_word_or_byte = ex_q.word_or_byte;
  assign ex_memtoreg     = ex_q.memtoreg;
  assign ex_aluop        = ex_q.aluop;
  assign ex_illegal      = ex_q.illegal;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: decode vector table, directed M-sequencer corners, and
// randomized traffic checked against an occupancy-based reference model (M enabled and disabled builds).
module tb_ctrl_pipe_unit;
  localparam int ALUOP_W = 5;
  localparam int MDC     = 4;

  typedef struct packed {
    logic       regwrite, alusrc, memread, memwrite, beq, bne, jal, jalr, wob;
    logic [1:0] memtoreg;
    logic [4:0] aluop;
    logic       valid, illegal;
  } bun_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [8:0] ctrl;
    logic [1:0] m2r;
    logic [4:0] aluop;
    logic       ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic funct7_0, hazard_stall, flush;

  logic u0_regwrite, u0_alusrc, u0_memread, u0_memwrite, u0_beq, u0_bne, u0_jal, u0_jalr, u0_wob;
  logic [1:0] u0_memtoreg;
  logic [4:0] u0_aluop;
  logic u0_valid, u0_illegal, u0_md_start, u0_md_busy;
  logic u1_regwrite, u1_alusrc, u1_memread, u1_memwrite, u1_beq, u1_bne, u1_jal, u1_jalr, u1_wob;
  logic [1:0] u1_memtoreg;
  logic [4:0] u1_aluop;
  logic u1_valid, u1_illegal, u1_md_start, u1_md_busy;

  bun_t act[2];
  assign act[0] = {u0_regwrite, u0_alusrc, u0_memread, u0_memwrite, u0_beq, u0_bne, u0_jal, u0_jalr,
                   u0_wob, u0_memtoreg, u0_aluop, u0_valid, u0_illegal};
  assign act[1] = {u1_regwrite, u1_alusrc, u1_memread, u1_memwrite, u1_beq, u1_bne, u1_jal, u1_jalr,
                   u1_wob, u1_memtoreg, u1_aluop, u1_valid, u1_illegal};

  ctrl_pipe_unit #(.ALUOP_W(ALUOP_W), .MULDIV_EN(1'b1), .MULDIV_CYCLES(MDC)) u0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_0(funct7_0),
    .hazard_stall(hazard_stall), .flush(flush),
    .ex_regwrite(u0_regwrite), .ex_alusrc(u0_alusrc), .ex_memread(u0_memread), .ex_memwrite(u0_memwrite),
    .ex_beq(u0_beq), .ex_bne(u0_bne), .ex_jal(u0_jal), .ex_jalr(u0_jalr), .ex_word_or_byte(u0_wob),
    .ex_memtoreg(u0_memtoreg), .ex_aluop(u0_aluop), .ex_valid(u0_valid), .ex_illegal(u0_illegal),
    .md_start(u0_md_start), .md_busy(u0_md_busy));

  ctrl_pipe_unit #(.ALUOP_W(ALUOP_W), .MULDIV_EN(1'b0), .MULDIV_CYCLES(MDC)) u1 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_0(funct7_0),
    .hazard_stall(hazard_stall), .flush(flush),
    .ex_regwrite(u1_regwrite), .ex_alusrc(u1_alusrc), .ex_memread(u1_memread), .ex_memwrite(u1_memwrite),
    .ex_beq(u1_beq), .ex_bne(u1_bne), .ex_jal(u1_jal), .ex_jalr(u1_jalr), .ex_word_or_byte(u1_wob),
    .ex_memtoreg(u1_memtoreg), .ex_aluop(u1_aluop), .ex_valid(u1_valid), .ex_illegal(u1_illegal),
    .md_start(u1_md_start), .md_busy(u1_md_busy));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit u1_start_seen = 1'b0;
  always @(posedge u1_md_start) u1_start_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: EX contents plus the number of further edges the EX stays occupied.
  bun_t m_ex[2];
  bit   m_start[2];
  int   m_occ[2];

  function automatic bun_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                      input bit md_en);
    bun_t b = '0;
    b.valid = 1'b1;
    case (op)
      7'h03: if (f3 == 0 || f3 == 2) begin
               b.memread = 1; b.memtoreg = 2'b01; b.alusrc = 1; b.regwrite = 1;
               b.aluop = 5'd6; b.wob = (f3 == 0);
             end else b.illegal = 1;
      7'h0D: if (f3 == 6)      begin b.aluop = 5'd5; b.alusrc = 1; b.regwrite = 1; end
             else if (f3 == 7) begin b.aluop = 5'd3; b.alusrc = 1; b.regwrite = 1; end
             else b.illegal = 1;
      7'h1B: if (f3 == 0) begin b.aluop = 5'd6; b.alusrc = 1; b.regwrite = 1; end
             else b.illegal = 1;
      7'h23: if (f3 == 0 || f3 == 2) begin
               b.memwrite = 1; b.alusrc = 1; b.aluop = 5'd6; b.wob = (f3 == 0);
             end else b.illegal = 1;
      7'h33: if (!f7)        begin b.aluop = 5'(f3);      b.regwrite = 1; end
             else if (md_en) begin b.aluop = 5'(16 + f3); b.regwrite = 1; end
             else b.illegal = 1;
      7'h38: begin b.aluop = 5'd8; b.alusrc = 1; b.regwrite = 1; end
      7'h63: if (f3 == 0)      begin b.bne = 1; b.aluop = 5'd7; end
             else if (f3 == 1) begin b.beq = 1; b.aluop = 5'd1; end
             else b.illegal = 1;
      7'h67: if (f3 == 0) begin b.jalr = 1; b.aluop = 5'd6; b.alusrc = 1; b.regwrite = 1; end
             else b.illegal = 1;
      7'h6F: begin b.jal = 1; b.aluop = 5'd6; b.memtoreg = 2'b10; b.alusrc = 1; b.regwrite = 1; end
      default: b.illegal = 1;
    endcase
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_start[k] = 0; m_occ[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit md_en = (k == 0);
      m_start[k] = 0;
      if (flush) begin
        m_ex[k] = '0; m_occ[k] = 0;
      end else if (m_occ[k] > 0) begin
        m_occ[k]--;
      end else if (hazard_stall) begin
        m_ex[k] = '0;
      end else begin
        m_ex[k] = ref_decode(opcode, funct3, funct7_0, md_en);
        if (md_en && opcode == 7'h33 && funct7_0) begin
          m_start[k] = 1; m_occ[k] = MDC - 1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " ex0"},    32'(act[0]),      32'(m_ex[0]));
    check({tag, " start0"}, 32'(u0_md_start), 32'(m_start[0]));
    check({tag, " busy0"},  32'(u0_md_busy),  32'(m_occ[0] > 0));
    check({tag, " ex1"},    32'(act[1]),      32'(m_ex[1]));
    check({tag, " start1"}, 32'(u1_md_start), 32'(m_start[1]));
    check({tag, " busy1"},  32'(u1_md_busy),  32'(m_occ[1] > 0));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    compare_all(tag);
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic st, input logic fl);
    opcode = op; funct3 = f3; funct7_0 = f7; hazard_stall = st; flush = fl;
  endtask

  vec_t vecs[$];
  logic [6:0] op_pool[10] = '{7'h03, 7'h0D, 7'h1B, 7'h23, 7'h33, 7'h38, 7'h63, 7'h67, 7'h6F, 7'h7F};

  initial begin
    int busy_cnt, start_cnt, landed, first_start, second_start;
    rst = 1'b1;
    set_in(7'h00, 3'b000, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    // Decode table: {opcode, funct3, funct7_0, regwrite..word_or_byte, memtoreg, aluop, illegal}
    vecs.push_back('{7'h03, 3'b000, 1'b0, 9'b111000001, 2'b01, 5'b00110, 1'b0});
    vecs.push_back('{7'h03, 3'b010, 1'b0, 9'b111000000, 2'b01, 5'b00110, 1'b0});
    vecs.push_back('{7'h03, 3'b001, 1'b0, 9'b000000000, 2'b00, 5'b00000, 1'b1});
    vecs.push_back('{7'h0D, 3'b110, 1'b0, 9'b110000000, 2'b00, 5'b00101, 1'b0});
    vecs.push_back('{7'h0D, 3'b111, 1'b0, 9'b110000000, 2'b00, 5'b00011, 1'b0});
    vecs.push_back('{7'h1B, 3'b000, 1'b1, 9'b110000000, 2'b00, 5'b00110, 1'b0});
    vecs.push_back('{7'h23, 3'b000, 1'b0, 9'b010100001, 2'b00, 5'b00110, 1'b0});
    vecs.push_back('{7'h23, 3'b010, 1'b0, 9'b010100000, 2'b00, 5'b00110, 1'b0});
    vecs.push_back('{7'h33, 3'b101, 1'b0, 9'b100000000, 2'b00, 5'b00101, 1'b0});
    vecs.push_back('{7'h38, 3'b011, 1'b0, 9'b110000000, 2'b00, 5'b01000, 1'b0});
    vecs.push_back('{7'h63, 3'b000, 1'b0, 9'b000001000, 2'b00, 5'b00111, 1'b0});
    vecs.push_back('{7'h63, 3'b001, 1'b0, 9'b000010000, 2'b00, 5'b00001, 1'b0});
    vecs.push_back('{7'h63, 3'b010, 1'b0, 9'b000000000, 2'b00, 5'b00000, 1'b1});
    vecs.push_back('{7'h67, 3'b000, 1'b0, 9'b110000010, 2'b00, 5'b00110, 1'b0});
    vecs.push_back('{7'h67, 3'b001, 1'b0, 9'b000000000, 2'b00, 5'b00000, 1'b1});
    vecs.push_back('{7'h6F, 3'b000, 1'b0, 9'b110000100, 2'b10, 5'b00110, 1'b0});
    vecs.push_back('{7'h7F, 3'b000, 1'b0, 9'b000000000, 2'b00, 5'b00000, 1'b1});
    foreach (vecs[i]) begin
      set_in(vecs[i].op, vecs[i].f3, vecs[i].f7, 1'b0, 1'b0);
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d table", i), 32'(act[0]),
            32'({vecs[i].ctrl, vecs[i].m2r, vecs[i].aluop, 1'b1, vecs[i].ill}));
    end

    // Bubble on hazard, then the held branch decodes.
    set_in(7'h63, 3'b000, 1'b0, 1'b1, 1'b0);
    step("stall");
    check("stall bubble", 32'(act[0]), 32'd0);
    hazard_stall = 1'b0;
    step("unstall");
    check("unstall bne", 32'({u0_bne, u0_aluop, u0_valid}), 32'({1'b1, 5'b00111, 1'b1}));

    // M op occupancy: one start pulse, MDC-1 busy cycles, next op lands MDC edges later.
    set_in(7'h33, 3'b000, 1'b1, 1'b0, 1'b0);
    step("md issue");
    check("md start pulse", 32'(u0_md_start), 32'd1);
    check("md aluop", 32'(u0_aluop), 32'b10000);
    check("nomd illegal", 32'({u1_illegal, u1_valid, u1_regwrite, u1_aluop}), 32'({1'b1, 1'b1, 1'b0, 5'd0}));
    busy_cnt = int'(u0_md_busy); start_cnt = 1; landed = 0;
    set_in(7'h1B, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      step($sformatf("md hold%0d", e));
      busy_cnt += int'(u0_md_busy);
      start_cnt += int'(u0_md_start);
      if (e < MDC) check($sformatf("md held aluop%0d", e), 32'(u0_aluop), 32'b10000);
      if (landed == 0 && u0_aluop == 5'b00110 && u0_valid) landed = e;
    end
    check("md busy cycles", 32'(busy_cnt), 32'(MDC - 1));
    check("md start count", 32'(start_cnt), 32'd1);
    check("md next lands", 32'(landed), 32'(MDC));

    // Flush in the second busy cycle aborts the op.
    set_in(7'h33, 3'b100, 1'b1, 1'b0, 1'b0);
    step("fl issue");
    set_in(7'h38, 3'b000, 1'b0, 1'b0, 1'b0);
    step("fl busy2");
    flush = 1'b1;
    step("fl edge");
    check("flush busy", 32'(u0_md_busy), 32'd0);
    check("flush valid", 32'(u0_valid), 32'd0);
    flush = 1'b0;
    step("fl after");
    check("flush next", 32'({u0_valid, u0_aluop}), 32'({1'b1, 5'b01000}));

    // Flush together with an M decode: no start.
    set_in(7'h33, 3'b001, 1'b1, 1'b0, 1'b1);
    step("fl+md");
    check("fl+md start", 32'({u0_md_start, u0_md_busy}), 32'd0);

    // Asynchronous reset mid-busy, then back-to-back M ops.
    set_in(7'h33, 3'b010, 1'b1, 1'b0, 1'b0);
    step("rst issue");
    #2 rst = 1'b1;
    #1;
    check("async rst ex", 32'(act[0]), 32'd0);
    check("async rst md", 32'({u0_md_start, u0_md_busy}), 32'd0);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst release start", 32'(u0_md_start), 32'd0);
    first_start = 0; second_start = 0;
    for (int e = 1; e <= 2 * MDC + 2; e++) begin
      step($sformatf("b2b%0d", e));
      if (u0_md_start) begin
        if (first_start == 0) first_start = e;
        else if (second_start == 0) second_start = e;
      end
    end
    check("b2b first start", 32'(first_start), 32'd1);
    check("b2b spacing", 32'(second_start - first_start), 32'(MDC));

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_pool[$urandom_range(0, 9)];
      set_in(op, 3'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0));
      step($sformatf("rnd%0d", n));
    end

    check("nomd never started", 32'(u1_start_seen), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
